// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// funct3 access codes and the alignment check used at accept time.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: req/gnt request phase, rvalid response phase.
// The LSU is the master; the memory (or bench model) is the slave.
interface load_store_unit_if #(
  parameter int XLEN = 32
) ();
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic for the LSU: store-side byte-enable and data
// replication, load-side byte/half extraction with sign or zero extension.
// Lane selection assumes four byte lanes per bus word.
module load_store_unit_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_addr_lo,
  input  logic [XLEN-1:0] st_data,
  output logic [3:0]      st_wstrb,
  output logic [XLEN-1:0] st_wdata,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Store steering: enable the addressed lanes and replicate data across all of them.
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = '0;
    case (st_funct3)
      F3_B: begin
        st_wstrb = 4'b0001 << st_addr_lo;
        st_wdata = {(XLEN/8){st_data[7:0]}};
      end
      F3_H: begin
        st_wstrb = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_wdata = {(XLEN/16){st_data[15:0]}};
      end
      F3_W: begin
        st_wstrb = 4'b1111;
        st_wdata = st_data;
      end
      default: begin
        st_wstrb = 4'b0000;
        st_wdata = '0;
      end
    endcase
  end

  // Load extraction: pick the addressed byte/half, then extend to full width.
  always_comb begin
    case (ld_addr_lo)
      2'b00:   ld_byte_s = ld_rdata[7:0];
      2'b01:   ld_byte_s = ld_rdata[15:8];
      2'b10:   ld_byte_s = ld_rdata[23:16];
      2'b11:   ld_byte_s = ld_rdata[31:24];
      default: ld_byte_s = ld_rdata[7:0];
    endcase
    if (ld_addr_lo[1]) begin
      ld_half_s = ld_rdata[31:16];
    end else begin
      ld_half_s = ld_rdata[15:0];
    end
    case (ld_funct3)
      F3_B:    ld_data = {{(XLEN-8){ld_byte_s[7]}}, ld_byte_s};
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, ld_byte_s};
      F3_H:    ld_data = {{(XLEN-16){ld_half_s[15]}}, ld_half_s};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, ld_half_s};
      F3_W:    ld_data = ld_rdata;
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access from execute, issues it on the
// req/gnt/rvalid data bus and returns extended load data to writeback.
// Single outstanding access; misaligned H/W accesses are trapped at accept.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  load_store_unit_if.master mem,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            store_done,
  output logic            err_valid,
  output logic [XLEN-1:0] err_addr
);

  lsu_state_e      state_r, state_next_s;
  logic            flushed_r, flushed_next_s;
  logic            we_r;
  logic [2:0]      funct3_r;
  logic [1:0]      addr_lo_r;
  logic [4:0]      rd_r;
  logic            req_ready_r, mem_req_r, mem_we_r;
  logic [XLEN-1:0] mem_addr_r, mem_wdata_r;
  logic [3:0]      mem_wstrb_r;
  logic            wb_valid_r, store_done_r, err_valid_r;
  logic [4:0]      wb_rd_r;
  logic [XLEN-1:0] wb_data_r, err_addr_r;
  logic            accept_s, misalign_s, launch_s;
  logic            store_done_s, wb_fire_s, err_s;
  logic [3:0]      st_wstrb_s;
  logic [XLEN-1:0] st_wdata_s, ld_data_s;

  assign accept_s   = req_valid && req_ready_r && !flush;
  assign misalign_s = (CHECK_ALIGN == 1'b1) && is_misaligned(req_funct3, req_addr[1:0]);
  assign launch_s   = accept_s && !misalign_s;

  load_store_unit_align #(.XLEN(XLEN)) u_align (
    .st_funct3  (req_funct3),
    .st_addr_lo (req_addr[1:0]),
    .st_data    (req_wdata),
    .st_wstrb   (st_wstrb_s),
    .st_wdata   (st_wdata_s),
    .ld_funct3  (funct3_r),
    .ld_addr_lo (addr_lo_r),
    .ld_rdata   (mem.mem_rdata),
    .ld_data    (ld_data_s)
  );

  // Next-state and completion pulses; a flushed access still finishes its bus
  // handshake but its result pulse is suppressed.
  always_comb begin
    state_next_s   = state_r;
    flushed_next_s = flushed_r;
    store_done_s   = 1'b0;
    wb_fire_s      = 1'b0;
    err_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          state_next_s   = ST_REQ;
          flushed_next_s = 1'b0;
        end else begin
          err_s = accept_s && misalign_s;
        end
      end
      ST_REQ: begin
        if (mem.mem_gnt) begin
          if (we_r) begin
            state_next_s = ST_IDLE;
            store_done_s = !flush;
          end else begin
            state_next_s   = ST_WAIT;
            flushed_next_s = flush;
          end
        end else if (flush) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem.mem_rvalid) begin
          state_next_s = ST_IDLE;
          wb_fire_s    = !(flushed_r || flush);
        end else if (flush) begin
          flushed_next_s = 1'b1;
        end else begin
          flushed_next_s = flushed_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      flushed_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      flushed_r <= flushed_next_s;
    end
  end

  // Access fields and bus outputs, captured at accept and held through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r        <= 1'b0;
      funct3_r    <= 3'b000;
      addr_lo_r   <= 2'b00;
      rd_r        <= 5'd0;
      req_ready_r <= 1'b1;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wstrb_r <= 4'b0000;
      mem_wdata_r <= '0;
    end else begin
      req_ready_r <= (state_next_s == ST_IDLE);
      mem_req_r   <= (state_next_s == ST_REQ);
      if (launch_s) begin
        we_r        <= req_we;
        funct3_r    <= req_funct3;
        addr_lo_r   <= req_addr[1:0];
        rd_r        <= req_rd;
        mem_we_r    <= req_we;
        mem_addr_r  <= {req_addr[XLEN-1:2], 2'b00};
        mem_wstrb_r <= st_wstrb_s;
        mem_wdata_r <= st_wdata_s;
      end else if (state_next_s != ST_REQ) begin
        mem_we_r <= 1'b0;
      end else begin
        mem_we_r <= mem_we_r;
      end
    end
  end

  // Result pulses toward writeback and the trap logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_r   <= 1'b0;
      wb_rd_r      <= 5'd0;
      wb_data_r    <= '0;
      store_done_r <= 1'b0;
      err_valid_r  <= 1'b0;
      err_addr_r   <= '0;
    end else begin
      wb_valid_r   <= wb_fire_s;
      store_done_r <= store_done_s;
      err_valid_r  <= err_s;
      if (wb_fire_s) begin
        wb_rd_r   <= rd_r;
        wb_data_r <= ld_data_s;
      end
      if (err_s) begin
        err_addr_r <= req_addr;
      end
    end
  end

  assign req_ready     = req_ready_r;
  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wstrb = mem_wstrb_r;
  assign mem.mem_wdata = mem_wdata_r;
  assign wb_valid      = wb_valid_r;
  assign wb_rd         = wb_rd_r;
  assign wb_data       = wb_data_r;
  assign store_done    = store_done_r;
  assign err_valid     = err_valid_r;
  assign err_addr      = err_addr_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses
// with hand-computed lane/extension results, then flush and reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        flush = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        store_done;
  logic        err_valid;
  logic [31:0] err_addr;

  int total = 0;
  int bad = 0;

  load_store_unit_if #(.XLEN(32)) mem_bus ();

  load_store_unit #(.XLEN(32), .CHECK_ALIGN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .flush      (flush),
    .mem        (mem_bus.master),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .store_done (store_done),
    .err_valid  (err_valid),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          gnt_dly;
    int          rv_dly;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] rd,
                              input int gd, input int rvd, input logic e_err, input logic [31:0] e_addr,
                              input logic [3:0] e_wstrb, input logic [31:0] e_wdata, input logic [31:0] e_wb);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rd = rd;
    v.gnt_dly = gd; v.rv_dly = rvd; v.exp_err = e_err; v.exp_addr = e_addr;
    v.exp_wstrb = e_wstrb; v.exp_wdata = e_wdata; v.exp_wb = e_wb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; req_rd = rd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    issue(v.we, v.f3, v.addr, v.wdata, v.rd);
    tick();
    req_valid = 1'b0;
    if (v.exp_err) begin
      chk($sformatf("v%0d err_valid", idx), {31'd0, err_valid}, 32'd1);
      chk($sformatf("v%0d err_addr", idx), err_addr, v.addr);
      chk($sformatf("v%0d err mem_req", idx), {31'd0, mem_bus.mem_req}, 32'd0);
      chk($sformatf("v%0d err req_ready", idx), {31'd0, req_ready}, 32'd1);
      tick();
      chk($sformatf("v%0d err one pulse", idx), {31'd0, err_valid}, 32'd0);
      chk($sformatf("v%0d err still no req", idx), {31'd0, mem_bus.mem_req}, 32'd0);
    end else begin
      chk($sformatf("v%0d mem_req", idx), {31'd0, mem_bus.mem_req}, 32'd1);
      chk($sformatf("v%0d busy", idx), {31'd0, req_ready}, 32'd0);
      chk($sformatf("v%0d mem_addr", idx), mem_bus.mem_addr, v.exp_addr);
      chk($sformatf("v%0d mem_we", idx), {31'd0, mem_bus.mem_we}, {31'd0, v.we});
      if (v.we) begin
        chk($sformatf("v%0d wstrb", idx), {28'd0, mem_bus.mem_wstrb}, {28'd0, v.exp_wstrb});
        chk($sformatf("v%0d wdata", idx), mem_bus.mem_wdata, v.exp_wdata);
      end
      for (int k = 0; k < v.gnt_dly; k++) begin
        tick();
        chk($sformatf("v%0d req held", idx), {31'd0, mem_bus.mem_req}, 32'd1);
        chk($sformatf("v%0d addr held", idx), mem_bus.mem_addr, v.exp_addr);
      end
      mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt = 1'b0;
      chk($sformatf("v%0d req drop", idx), {31'd0, mem_bus.mem_req}, 32'd0);
      if (v.we) begin
        chk($sformatf("v%0d store_done", idx), {31'd0, store_done}, 32'd1);
        chk($sformatf("v%0d ready after store", idx), {31'd0, req_ready}, 32'd1);
        tick();
        chk($sformatf("v%0d store_done once", idx), {31'd0, store_done}, 32'd0);
      end else begin
        chk($sformatf("v%0d wb early", idx), {31'd0, wb_valid}, 32'd0);
        for (int k = 0; k < v.rv_dly; k++) begin
          tick();
          chk($sformatf("v%0d wb wait", idx), {31'd0, wb_valid}, 32'd0);
        end
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata = v.rdata;
        tick();
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata = 32'd0;
        chk($sformatf("v%0d wb_valid", idx), {31'd0, wb_valid}, 32'd1);
        chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_wb);
        chk($sformatf("v%0d wb_rd", idx), {27'd0, wb_rd}, {27'd0, v.rd});
        chk($sformatf("v%0d ready after load", idx), {31'd0, req_ready}, 32'd1);
        tick();
        chk($sformatf("v%0d wb once", idx), {31'd0, wb_valid}, 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem_bus.mem_gnt = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata = 32'd0;

    //          we    f3      addr          wdata         rdata         rd     gd rv err   exp_addr      wstrb    exp_wdata     exp_wb
    vecs[0]  = mk(1'b0, 3'b010, 32'h00000100, 32'h0,        32'hDEADBEEF, 5'd1,  0, 0, 1'b0, 32'h00000100, 4'b0000, 32'h0,        32'hDEADBEEF);
    vecs[1]  = mk(1'b0, 3'b000, 32'h00000103, 32'h0,        32'h80FF0000, 5'd2,  1, 0, 1'b0, 32'h00000100, 4'b0000, 32'h0,        32'hFFFFFF80);
    vecs[2]  = mk(1'b0, 3'b100, 32'h00000103, 32'h0,        32'h80FF0000, 5'd3,  0, 2, 1'b0, 32'h00000100, 4'b0000, 32'h0,        32'h00000080);
    vecs[3]  = mk(1'b0, 3'b001, 32'h00000102, 32'h0,        32'h80FF0000, 5'd4,  0, 0, 1'b0, 32'h00000100, 4'b0000, 32'h0,        32'hFFFF80FF);
    vecs[4]  = mk(1'b0, 3'b101, 32'h00000102, 32'h0,        32'h80FF0000, 5'd5,  2, 1, 1'b0, 32'h00000100, 4'b0000, 32'h0,        32'h000080FF);
    vecs[5]  = mk(1'b0, 3'b000, 32'h00000101, 32'h0,        32'h12345678, 5'd6,  0, 0, 1'b0, 32'h00000100, 4'b0000, 32'h0,        32'h00000056);
    vecs[6]  = mk(1'b0, 3'b001, 32'h00000200, 32'h0,        32'h1234F00D, 5'd7,  0, 0, 1'b0, 32'h00000200, 4'b0000, 32'h0,        32'hFFFFF00D);
    vecs[7]  = mk(1'b1, 3'b000, 32'h00000201, 32'h000000AB, 32'h0,        5'd0,  0, 0, 1'b0, 32'h00000200, 4'b0010, 32'hABABABAB, 32'h0);
    vecs[8]  = mk(1'b1, 3'b001, 32'h00000302, 32'h0000BEEF, 32'h0,        5'd0,  3, 0, 1'b0, 32'h00000300, 4'b1100, 32'hBEEFBEEF, 32'h0);
    vecs[9]  = mk(1'b1, 3'b010, 32'h00000304, 32'hCAFEF00D, 32'h0,        5'd0,  0, 0, 1'b0, 32'h00000304, 4'b1111, 32'hCAFEF00D, 32'h0);
    vecs[10] = mk(1'b0, 3'b010, 32'h00000102, 32'h0,        32'h0,        5'd8,  0, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[11] = mk(1'b1, 3'b001, 32'h00000401, 32'h00001234, 32'h0,        5'd0,  0, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[12] = mk(1'b0, 3'b001, 32'h00000101, 32'h0,        32'h0,        5'd9,  0, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[13] = mk(1'b1, 3'b000, 32'h00000403, 32'h12345677, 32'h0,        5'd0,  1, 0, 1'b0, 32'h00000400, 4'b1000, 32'h77777777, 32'h0);

    // Reset values while rst_n is held low.
    #12;
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("rst mem_we", {31'd0, mem_bus.mem_we}, 32'd0);
    chk("rst mem_addr", mem_bus.mem_addr, 32'd0);
    chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst store_done", {31'd0, store_done}, 32'd0);
    chk("rst err_valid", {31'd0, err_valid}, 32'd0);
    #10;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], i);
    end

    // Load with grant held off five cycles, then flush while waiting for data.
    issue(1'b0, 3'b010, 32'h00000500, 32'h0, 5'd10);
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("A req held", {31'd0, mem_bus.mem_req}, 32'd1);
      tick();
    end
    mem_bus.mem_gnt = 1'b1;
    tick();
    mem_bus.mem_gnt = 1'b0;
    chk("A waiting", {31'd0, req_ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("A still waiting", {31'd0, req_ready}, 32'd0);
    tick();
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata = 32'h11111111;
    tick();
    mem_bus.mem_rvalid = 1'b0;
    chk("A wb suppressed", {31'd0, wb_valid}, 32'd0);
    chk("A idle after", {31'd0, req_ready}, 32'd1);
    tick();
    chk("A wb suppressed late", {31'd0, wb_valid}, 32'd0);

    // Flush in REQ before grant: request abandoned, no pulses.
    issue(1'b1, 3'b010, 32'h00000A00, 32'h55555555, 5'd0);
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("B req dropped", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("B idle", {31'd0, req_ready}, 32'd1);
    chk("B no store_done", {31'd0, store_done}, 32'd0);
    tick();
    chk("B no store_done late", {31'd0, store_done}, 32'd0);

    // Flush coincident with grant on a store: completes silently.
    issue(1'b1, 3'b010, 32'h00000800, 32'h00000001, 5'd0);
    tick();
    req_valid = 1'b0;
    mem_bus.mem_gnt = 1'b1;
    flush = 1'b1;
    tick();
    mem_bus.mem_gnt = 1'b0;
    flush = 1'b0;
    chk("C store_done suppressed", {31'd0, store_done}, 32'd0);
    chk("C req dropped", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("C idle", {31'd0, req_ready}, 32'd1);

    // Flush coincident with grant on a load: waits for data, no writeback.
    issue(1'b0, 3'b010, 32'h00000900, 32'h0, 5'd11);
    tick();
    req_valid = 1'b0;
    mem_bus.mem_gnt = 1'b1;
    flush = 1'b1;
    tick();
    mem_bus.mem_gnt = 1'b0;
    flush = 1'b0;
    chk("D waiting", {31'd0, req_ready}, 32'd0);
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata = 32'h22222222;
    tick();
    mem_bus.mem_rvalid = 1'b0;
    chk("D wb suppressed", {31'd0, wb_valid}, 32'd0);
    chk("D idle", {31'd0, req_ready}, 32'd1);

    // Flush alongside req_valid in IDLE: not accepted, even a misaligned one.
    issue(1'b0, 3'b010, 32'h00000602, 32'h0, 5'd12);
    flush = 1'b1;
    tick();
    req_valid = 1'b0;
    flush = 1'b0;
    chk("E no req", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("E no err", {31'd0, err_valid}, 32'd0);
    chk("E ready", {31'd0, req_ready}, 32'd1);

    // Asynchronous reset in REQ, then a normal load.
    issue(1'b0, 3'b010, 32'h00000700, 32'h0, 5'd13);
    tick();
    req_valid = 1'b0;
    chk("F in REQ", {31'd0, mem_bus.mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("F async mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("F async ready", {31'd0, req_ready}, 32'd1);
    chk("F async mem_addr", mem_bus.mem_addr, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    run_vec(mk(1'b0, 3'b010, 32'h00000104, 32'h0, 32'h0BADF00D, 5'd14, 0, 0, 1'b0,
               32'h00000104, 4'b0000, 32'h0, 32'h0BADF00D), 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
